inst_fetch_axi_bridge: RTL and testbench
========================================

# inst_fetch_axi_bridge

Responder side of the instruction-fetch request/response interface. It accepts fetch requests from the pre-IF stage using `inst_req`/`inst_addr_ok`, issues one single-beat AXI read per request, and returns each word on `inst_data_ok`/`inst_rdata` to the IF stage in request order. Every accepted request yields exactly one `inst_data_ok` pulse, including requests made stale by exceptions, eret or branch cancel. Discarding stale words is the IF stage's job, so the bridge has no cancel input.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum accepted requests not yet answered, range 1..7.
- `ARID`, default 4'd0: fixed AXI ID driven on `arid`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `inst_req` in 1: fetch request valid.
- `inst_addr` in 32: fetch address, word aligned.
- `inst_addr_ok` out 1: request accepted this cycle.
- `inst_data_ok` out 1: one-cycle pulse; `inst_rdata` is valid.
- `inst_rdata` out 32: fetched instruction.
- `inst_bus_err` out 1: error flag qualified by `inst_data_ok`. See Configuration.
- AXI read-address channel outputs:
  - `arid` 4, `araddr` 32, `arlen` 8, `arsize` 3, `arburst` 2, `arlock` 2, `arcache` 4, `arprot` 3, `arvalid` 1.
- `arready` in 1: AXI read-address ready.
- AXI read-data channel inputs: `rid` 4, `rdata` 32, `rresp` 2, `rlast` 1, `rvalid` 1.
- `rready` out 1: AXI read-data ready.

## Operation
- **Constant AR fields:** `arid`=ARID, `arlen`=0, `arsize`=3'b010, `arburst`=2'b01. `arlock`, `arcache` and `arprot` are 0.
- **Outstanding counter `cnt`:** 3 bits wide.
  - Increments on accept, i.e. `inst_req & inst_addr_ok`.
  - Decrements on a counted response (defined below).
  - Accept and counted response in the same cycle: `cnt` is unchanged.
- **Accept condition:** `inst_addr_ok` = `!arvalid & (cnt < MAX_OUTSTANDING)`. It is combinational from registers only and never depends on `inst_req` or `arready`.
- **AR holding register:**
  - On accept: `araddr` <= `inst_addr` and `arvalid` <= 1.
  - `arvalid` stays high until `arvalid & arready`, then clears.
  - `araddr` is stable while `arvalid` is high.
- **State machine:**
  - AR_IDLE (`arvalid`=0) -> AR_BUSY on accept.
  - AR_BUSY -> AR_IDLE on `arready`.
  - No accept is possible in AR_BUSY.
- **R channel:**
  - `rready` is 1 in every non-reset cycle.
  - A beat is counted when `rvalid & rlast & rid==ARID & cnt!=0`.
  - A beat with a mismatching `rid`, or arriving with `cnt==0`, is consumed silently: no `inst_data_ok`, and `cnt` does not underflow.
- **Response output:** on a counted beat, the next cycle carries `inst_data_ok`=1 and `inst_rdata`=`rdata`.
  - `inst_rdata` holds its last value until the next counted beat.
  - `inst_data_ok` is 0 in every other cycle.
- **Ordering:** AXI returns same-ID reads in order, so responses leave the bridge in acceptance order.

## Timing
- Reset values:
  - `arvalid`=0, `araddr`=0, `rready`=0, `cnt`=0.
  - `inst_data_ok`=0, `inst_rdata`=0, `inst_bus_err`=0.
  - `inst_addr_ok`=0 during reset, because it is gated by reset.
- `rready` rises in the first cycle after reset deasserts.
- Accept at cycle T: `arvalid`=1 from T+1. With `arready`=1 at T+1, the next accept is possible at T+2. Peak rate is 1 request per 2 cycles.
- Counted R beat at cycle R: `inst_data_ok` at R+1. Minimum request-to-data latency is 3 cycles.
- At `cnt==MAX_OUTSTANDING`, `inst_addr_ok`=0. If a counted beat occurs at cycle C, `inst_addr_ok` may rise at C+1.
- **Reset mid-operation:** all state is cleared and pending AR and R transactions are abandoned. The interconnect is reset on the same signal. Late beats are absorbed by the `cnt==0` drop rule.

## Configuration
- **`IFETCH_RRESP_ERR_EN` defined:** `inst_bus_err` is registered alongside `inst_data_ok`. It equals `(rresp != 2'b00)` of the counted beat and is valid only while `inst_data_ok`=1; otherwise it is 0.
- **Not defined:** `rresp` is ignored and `inst_bus_err` is constant 0.

## Test plan
- **Single fetch:** `inst_req`=1 with `inst_addr`=0xBFC00000 at T, `arready`=1 at T+1, R beat with `rdata`=0x3C080001 at T+3 -> `inst_addr_ok`=1 at T; `araddr`=0xBFC00000 and `arvalid`=1 at T+1; `inst_data_ok`=1 with `inst_rdata`=0x3C080001 at T+4.
- **Outstanding limit (MAX=2):** two requests accepted with no R beats returned -> `inst_addr_ok`=0 thereafter. Return one beat -> `inst_addr_ok`=1 the following cycle.
- **AR stall:** hold `arready`=0 for 5 cycles -> `arvalid` and `araddr` are stable throughout; `inst_addr_ok`=0 until the cycle after `arready`.
- **Stray beats:**
  - Beat with `rid`=4'd1, ARID=0 -> no `inst_data_ok`; `cnt` unchanged.
  - Beat with `cnt`=0 -> no `inst_data_ok`; `cnt` stays 0.
- **Same-cycle events:** at `cnt`=1, a counted beat and an accept in the same cycle -> `cnt` stays 1 and `inst_data_ok` fires next cycle.
- **Error and reset:**
  - With `IFETCH_RRESP_ERR_EN`, `rresp`=2'b10 -> `inst_bus_err`=1 together with `inst_data_ok`.
  - Reset asserted while `arvalid`=1 -> next cycle `arvalid`=0, `cnt`=0, `rready`=0.

Source files
------------

// File: rtl/inst_fetch_axi_bridge_if.sv
//==============================================================================
// Module   : inst_fetch_axi_bridge_if
// Brief    : Fetch request/response bus plus AXI read channels for the bridge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface inst_fetch_axi_bridge_if;
    // Fetch request/response side
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_bus_err;

    // AXI read-address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    // AXI read-data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // slave: the bridge itself; master: the pre-IF/IF stages and the interconnect
    modport slave (
        input  inst_req, inst_addr, arready, rid, rdata, rresp, rlast, rvalid,
        output inst_addr_ok, inst_data_ok, inst_rdata, inst_bus_err,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready
    );

    modport master (
        output inst_req, inst_addr, arready, rid, rdata, rresp, rlast, rvalid,
        input  inst_addr_ok, inst_data_ok, inst_rdata, inst_bus_err,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_axi_bridge.sv
//==============================================================================
// Module   : inst_fetch_axi_bridge
// Brief    : Instruction-fetch responder issuing one single-beat AXI read per
//            request. Optional macro IFETCH_RRESP_ERR_EN reports rresp errors.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_fetch_axi_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] ARID            = 4'd0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    inst_fetch_axi_bridge_if.slave bus
);

    localparam logic [2:0] c_max_outstanding = 3'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_t;

    ar_state_t   ar_state_q;
    logic [31:0] araddr_q;

    logic [2:0]  cnt_q,      cnt_d;
    logic        rready_q,   rready_d;
    logic        data_ok_q,  data_ok_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        bus_err_q,  bus_err_d;

    logic        w_accept;
    logic        w_counted;
    logic        unused_rresp;

    // Accept never looks at inst_req or arready, only at registered state.
    assign bus.inst_addr_ok = !reset && (ar_state_q == AR_IDLE) && (cnt_q < c_max_outstanding);
    assign w_accept         = bus.inst_req & bus.inst_addr_ok;

    // Beats with a foreign ID or with nothing outstanding are consumed silently.
    assign w_counted = rready_q & bus.rvalid & bus.rlast & (bus.rid == ARID) & (cnt_q != 3'd0);

    always_comb begin
        cnt_d     = cnt_q;
        rready_d  = 1'b1;
        data_ok_d = w_counted;
        rdata_d   = w_counted ? bus.rdata : rdata_q;
        if (w_accept && !w_counted) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!w_accept && w_counted) begin
            cnt_d = cnt_q - 3'd1;
        end
`ifdef IFETCH_RRESP_ERR_EN
        bus_err_d = w_counted && (bus.rresp != 2'b00);
`else
        bus_err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 3'd0;
            rready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rready_q  <= rready_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    // AR channel: the address is captured on accept and held until arready.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_q <= AR_IDLE;
            araddr_q   <= 32'd0;
        end else begin
            case (ar_state_q)
                AR_IDLE: begin
                    if (w_accept) begin
                        ar_state_q <= AR_BUSY;
                        araddr_q   <= bus.inst_addr;
                    end
                end
                AR_BUSY: begin
                    if (bus.arready) begin
                        ar_state_q <= AR_IDLE;
                    end
                end
                default: ar_state_q <= AR_IDLE;
            endcase
        end
    end

    assign bus.arid    = ARID;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = (ar_state_q == AR_BUSY);
    assign bus.rready  = rready_q;

    assign bus.inst_data_ok = data_ok_q;
    assign bus.inst_rdata   = rdata_q;
    assign bus.inst_bus_err = bus_err_q;

    assign unused_rresp = ^bus.rresp;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_axi_bridge.sv
//==============================================================================
// Module   : tb_inst_fetch_axi_bridge
// Brief    : Directed self-checking bench for inst_fetch_axi_bridge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_inst_fetch_axi_bridge;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    inst_fetch_axi_bridge_if bus ();

    inst_fetch_axi_bridge #(
        .MAX_OUTSTANDING (2),
        .ARID            (4'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IFETCH_RRESP_ERR_EN
    localparam logic c_err_expected = 1'b1;
`else
    localparam logic c_err_expected = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp);
        bus.rvalid = 1'b1;
        bus.rlast  = 1'b1;
        bus.rid    = id;
        bus.rdata  = data;
        bus.rresp  = resp;
    endtask

    task automatic no_beat();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rid    = 4'd0;
        bus.rdata  = 32'd0;
        bus.rresp  = 2'b00;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.inst_req = 1'b0;
        bus.inst_addr = 32'd0;
        bus.arready  = 1'b0;
        no_beat();

        // Reset state
        tick();
        tick();
        settle();
        check_eq("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check_eq("rst_araddr", bus.araddr, 32'd0);
        check_eq("rst_rready", 32'(bus.rready), 32'd0);
        check_eq("rst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
        check_eq("rst_data_ok", 32'(bus.inst_data_ok), 32'd0);
        check_eq("rst_rdata", bus.inst_rdata, 32'd0);
        check_eq("rst_bus_err", 32'(bus.inst_bus_err), 32'd0);
        check_eq("rst_cnt", 32'(dut.cnt_q), 32'd0);
        check_eq("const_arsize", 32'(bus.arsize), 32'd2);
        check_eq("const_arburst", 32'(bus.arburst), 32'd1);
        check_eq("const_arlen", 32'(bus.arlen), 32'd0);

        reset = 1'b0;
        tick();
        tick();
        settle();
        check_eq("rready_up", 32'(bus.rready), 32'd1);

        // Single fetch: request at T
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0000;
        settle();
        check_eq("sf_addr_ok_T", 32'(bus.inst_addr_ok), 32'd1);
        tick();
        bus.inst_req = 1'b0;
        bus.arready  = 1'b1;
        settle();
        check_eq("sf_arvalid_T1", 32'(bus.arvalid), 32'd1);
        check_eq("sf_araddr_T1", bus.araddr, 32'hBFC0_0000);
        check_eq("sf_addr_ok_T1", 32'(bus.inst_addr_ok), 32'd0);
        tick();
        bus.arready = 1'b0;
        settle();
        check_eq("sf_arvalid_T2", 32'(bus.arvalid), 32'd0);
        check_eq("sf_cnt_T2", 32'(dut.cnt_q), 32'd1);
        tick();
        beat(4'd0, 32'h3C08_0001, 2'b00);
        settle();
        check_eq("sf_data_ok_T3", 32'(bus.inst_data_ok), 32'd0);
        tick();
        no_beat();
        settle();
        check_eq("sf_data_ok_T4", 32'(bus.inst_data_ok), 32'd1);
        check_eq("sf_rdata_T4", bus.inst_rdata, 32'h3C08_0001);
        check_eq("sf_bus_err_T4", 32'(bus.inst_bus_err), 32'd0);
        check_eq("sf_cnt_T4", 32'(dut.cnt_q), 32'd0);
        tick();
        settle();
        check_eq("sf_data_ok_T5", 32'(bus.inst_data_ok), 32'd0);
        check_eq("sf_rdata_hold", bus.inst_rdata, 32'h3C08_0001);

        // Outstanding limit with MAX=2, back-to-back at peak rate
        bus.arready   = 1'b1;
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0100;
        settle();
        check_eq("lim_accept0", 32'(bus.inst_addr_ok), 32'd1);
        tick();
        settle();
        check_eq("lim_busy", 32'(bus.inst_addr_ok), 32'd0);
        tick();
        bus.inst_addr = 32'h0000_0104;
        settle();
        check_eq("lim_accept1", 32'(bus.inst_addr_ok), 32'd1);
        tick();
        settle();
        check_eq("lim_araddr1", bus.araddr, 32'h0000_0104);
        tick();
        settle();
        check_eq("lim_full_ok", 32'(bus.inst_addr_ok), 32'd0);
        check_eq("lim_full_cnt", 32'(dut.cnt_q), 32'd2);
        tick();
        beat(4'd0, 32'h1111_1111, 2'b00);
        settle();
        check_eq("lim_still_full", 32'(bus.inst_addr_ok), 32'd0);
        tick();
        bus.inst_req = 1'b0;
        beat(4'd0, 32'h2222_2222, 2'b00);
        settle();
        check_eq("lim_reopen", 32'(bus.inst_addr_ok), 32'd1);
        check_eq("lim_data_ok0", 32'(bus.inst_data_ok), 32'd1);
        check_eq("lim_rdata0", bus.inst_rdata, 32'h1111_1111);
        check_eq("lim_cnt1", 32'(dut.cnt_q), 32'd1);
        tick();
        no_beat();
        settle();
        check_eq("lim_data_ok1", 32'(bus.inst_data_ok), 32'd1);
        check_eq("lim_rdata1", bus.inst_rdata, 32'h2222_2222);
        check_eq("lim_cnt0", 32'(dut.cnt_q), 32'd0);

        // Stray beat with nothing outstanding
        beat(4'd0, 32'hDEAD_BEEF, 2'b00);
        tick();
        no_beat();
        settle();
        check_eq("stray0_data_ok", 32'(bus.inst_data_ok), 32'd0);
        check_eq("stray0_cnt", 32'(dut.cnt_q), 32'd0);
        check_eq("stray0_rdata", bus.inst_rdata, 32'h2222_2222);

        // One outstanding, then a beat with a foreign ID
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0200;
        tick();
        bus.inst_req = 1'b0;
        tick();
        beat(4'd1, 32'hCAFE_0001, 2'b00);
        tick();
        no_beat();
        settle();
        check_eq("stray_id_data_ok", 32'(bus.inst_data_ok), 32'd0);
        check_eq("stray_id_cnt", 32'(dut.cnt_q), 32'd1);

        // Counted beat and accept in the same cycle at cnt=1
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0300;
        beat(4'd0, 32'h3333_3333, 2'b00);
        settle();
        check_eq("same_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
        tick();
        bus.inst_req = 1'b0;
        bus.arready  = 1'b0;
        no_beat();
        settle();
        check_eq("same_data_ok", 32'(bus.inst_data_ok), 32'd1);
        check_eq("same_rdata", bus.inst_rdata, 32'h3333_3333);
        check_eq("same_cnt", 32'(dut.cnt_q), 32'd1);

        // AR stall: arready low for 5 cycles
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("stall_arvalid%0d", i), 32'(bus.arvalid), 32'd1);
            check_eq($sformatf("stall_araddr%0d", i), bus.araddr, 32'h0000_0300);
            check_eq($sformatf("stall_addr_ok%0d", i), 32'(bus.inst_addr_ok), 32'd0);
            tick();
        end
        bus.arready = 1'b1;
        settle();
        check_eq("stall_release_ok", 32'(bus.inst_addr_ok), 32'd0);
        tick();
        bus.arready = 1'b0;
        settle();
        check_eq("stall_arvalid_clr", 32'(bus.arvalid), 32'd0);
        check_eq("stall_after_ok", 32'(bus.inst_addr_ok), 32'd1);

        // Error response on the outstanding read
        beat(4'd0, 32'h4444_4444, 2'b10);
        tick();
        no_beat();
        settle();
        check_eq("err_data_ok", 32'(bus.inst_data_ok), 32'd1);
        check_eq("err_rdata", bus.inst_rdata, 32'h4444_4444);
        check_eq("err_flag", 32'(bus.inst_bus_err), 32'(c_err_expected));
        tick();
        settle();
        check_eq("err_flag_clr", 32'(bus.inst_bus_err), 32'd0);

        // Reset while arvalid is high
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0400;
        tick();
        bus.inst_req = 1'b0;
        settle();
        check_eq("mid_arvalid", 32'(bus.arvalid), 32'd1);
        reset = 1'b1;
        tick();
        settle();
        check_eq("mid_rst_arvalid", 32'(bus.arvalid), 32'd0);
        check_eq("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
        check_eq("mid_rst_rready", 32'(bus.rready), 32'd0);
        check_eq("mid_rst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        beat(4'd0, 32'h5555_5555, 2'b00);
        tick();
        no_beat();
        settle();
        check_eq("late_data_ok", 32'(bus.inst_data_ok), 32'd0);
        check_eq("late_cnt", 32'(dut.cnt_q), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
